// File: rtl/disp_pkg.sv
// Shared definitions for the BCD scanning display.
//   - conv_state_t : conversion FSM state encoding
//   - SEG_BLANK    : all segments off (active-low)
//   - seg_encode   : BCD digit -> active-low {g,f,e,d,c,b,a} code
//   - clog2        : width helper for counters (never returns less than 1)
package disp_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } conv_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_encode(input logic [3:0] i_Digit);
    logic [6:0] v_Seg;
    case (i_Digit)
      4'd0:    v_Seg = 7'b1000000;
      4'd1:    v_Seg = 7'b1111001;
      4'd2:    v_Seg = 7'b0100100;
      4'd3:    v_Seg = 7'b0110000;
      4'd4:    v_Seg = 7'b0011001;
      4'd5:    v_Seg = 7'b0010010;
      4'd6:    v_Seg = 7'b0000010;
      4'd7:    v_Seg = 7'b1111000;
      4'd8:    v_Seg = 7'b0000000;
      4'd9:    v_Seg = 7'b0010000;
      default: v_Seg = SEG_BLANK;
    endcase
    return v_Seg;
  endfunction

  function automatic int unsigned clog2(input int unsigned i_Val);
    int unsigned v_W;
    v_W = 1;
    while ((64'd1 << v_W) < 64'(i_Val)) v_W++;
    return v_W;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 (double dabble) binary to BCD converter.
//   i_Clk    system clock, rising edge
//   i_Rst    asynchronous reset, active-low (aborts a conversion)
//   i_Start  start request, sampled only while idle
//   i_Bin    N-bit binary value, captured on the start edge
//   o_Bcd    4*DIGITS-bit result, valid while o_Done is high
//   o_Done   high during the final shift cycle; the consumer captures o_Bcd on that edge
//   o_Busy   high for exactly N clocks per conversion
module bin2bcd_seq
  import disp_pkg::*;
#(
  parameter int N      = 8,
  parameter int DIGITS = 3
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic                  i_Start,
  input  logic [N-1:0]          i_Bin,
  output logic [4*DIGITS-1:0]   o_Bcd,
  output logic                  o_Done,
  output logic                  o_Busy
);

  localparam int CNT_W = clog2(N + 1);

  conv_state_t            r_State, w_NextState;
  logic [N-1:0]           r_Bin, w_NextBin;
  logic [4*DIGITS-1:0]    r_Bcd, w_NextBcd, w_Adj;
  logic [CNT_W-1:0]       r_Cnt, w_NextCnt;
  logic [4*DIGITS+N-1:0]  w_Sh;

  // Add-3 correction on every nibble >= 5, then one left shift of {bcd,bin}.
  always_comb begin
    w_Adj = r_Bcd;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (r_Bcd[4*i +: 4] >= 4'd5) w_Adj[4*i +: 4] = r_Bcd[4*i +: 4] + 4'd3;
    end
    w_Sh = {w_Adj, r_Bin} << 1;
  end

  // The result is presented combinationally on the last shift so the
  // consumer's display register updates on the same edge the FSM goes idle.
  assign o_Bcd  = w_Sh[4*DIGITS+N-1:N];
  assign o_Busy = (r_State == ST_SHIFT);

  always_comb begin
    w_NextState = r_State;
    w_NextBin   = r_Bin;
    w_NextBcd   = r_Bcd;
    w_NextCnt   = r_Cnt;
    o_Done      = 1'b0;
    case (r_State)
      ST_IDLE: begin
        if (i_Start) begin
          w_NextState = ST_SHIFT;
          w_NextBin   = i_Bin;
          w_NextBcd   = '0;
          w_NextCnt   = CNT_W'(N);
        end
      end
      ST_SHIFT: begin
        w_NextBin = w_Sh[N-1:0];
        w_NextBcd = w_Sh[4*DIGITS+N-1:N];
        w_NextCnt = r_Cnt - 1'b1;
        if (r_Cnt == CNT_W'(1)) begin
          w_NextState = ST_IDLE;
          o_Done      = 1'b1;
        end
      end
      default: w_NextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_State <= ST_IDLE;
      r_Bin   <= '0;
      r_Bcd   <= '0;
      r_Cnt   <= '0;
    end else begin
      r_State <= w_NextState;
      r_Bin   <= w_NextBin;
      r_Bcd   <= w_NextBcd;
      r_Cnt   <= w_NextCnt;
    end
  end

endmodule

// File: rtl/display_scan_bcd.sv
// Multiplexed common-anode 7-segment display of a binary count, shown in
// decimal with leading-zero blanking.
//   i_Clk   system clock, rising edge
//   i_Rst   asynchronous reset, active-low
//   i_Val   N-bit value to display
//   o_Seg   segments {g,f,e,d,c,b,a}, active-low, registered
//   o_An    anode enables, active-low one-hot, registered; bit 0 = LS digit
//   o_Busy  high while a conversion is in progress
module display_scan_bcd
  import disp_pkg::*;
#(
  parameter int N           = 8,
  parameter int DIGITS      = 3,
  parameter int REFRESH_DIV = 50000
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic [N-1:0]      i_Val,
  output logic [6:0]        o_Seg,
  output logic [DIGITS-1:0] o_An,
  output logic              o_Busy
);

  localparam int PRE_W = clog2(REFRESH_DIV);
  localparam int IDX_W = clog2(DIGITS);

  if (10**DIGITS <= 2**N) begin : g_bad_digits
    $error("display_scan_bcd: DIGITS too small for N-bit values");
  end
  if (REFRESH_DIV < 2) begin : g_bad_div
    $error("display_scan_bcd: REFRESH_DIV must be at least 2");
  end

  logic [N-1:0]         r_LastVal;
  logic [4*DIGITS-1:0]  r_Disp;
  logic [PRE_W-1:0]     r_Pre;
  logic [IDX_W-1:0]     r_Idx;
  logic [6:0]           r_Seg;
  logic [DIGITS-1:0]    r_An;

  logic                 w_Start, w_Done, w_Busy;
  logic [4*DIGITS-1:0]  w_Bcd;
  logic [DIGITS-1:0]    w_Blank;
  logic [3:0]           w_Digit;
  logic                 w_DigitBlank;

  // Changes seen while busy are simply re-compared once the converter is idle.
  assign w_Start = !w_Busy && (i_Val != r_LastVal);

  bin2bcd_seq #(
    .N      (N),
    .DIGITS (DIGITS)
  ) u_conv (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .i_Start (w_Start),
    .i_Bin   (i_Val),
    .o_Bcd   (w_Bcd),
    .o_Done  (w_Done),
    .o_Busy  (w_Busy)
  );

  // Walk down from the top digit: a digit is blank while everything from it
  // upward is zero. Digit 0 always shows.
  always_comb begin
    logic v_Zero;
    v_Zero  = 1'b1;
    w_Blank = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      v_Zero = v_Zero && (r_Disp[4*(DIGITS-1-k) +: 4] == 4'd0);
      w_Blank[DIGITS-1-k] = v_Zero && (k != DIGITS - 1);
    end
  end

  always_comb begin
    w_Digit      = '0;
    w_DigitBlank = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (r_Idx == IDX_W'(i)) begin
        w_Digit      = r_Disp[4*i +: 4];
        w_DigitBlank = w_Blank[i];
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_LastVal <= '0;
      r_Disp    <= '0;
      r_Pre     <= '0;
      r_Idx     <= '0;
      r_Seg     <= SEG_BLANK;
      r_An      <= '1;
    end else begin
      if (w_Start) r_LastVal <= i_Val;
      if (w_Done)  r_Disp    <= w_Bcd;

      if (r_Pre == PRE_W'(REFRESH_DIV - 1)) begin
        r_Pre <= '0;
        r_Idx <= (r_Idx == IDX_W'(DIGITS - 1)) ? '0 : r_Idx + 1'b1;
      end else begin
        r_Pre <= r_Pre + 1'b1;
      end

      r_An  <= ~(DIGITS'(1) << r_Idx);
      r_Seg <= w_DigitBlank ? SEG_BLANK : seg_encode(w_Digit);
    end
  end

  assign o_Seg  = r_Seg;
  assign o_An   = r_An;
  assign o_Busy = w_Busy;

endmodule
